// File: rtl/branch_predictor_bht_pkg.sv
// Shared constants and saturating-counter helpers for the BTB/BHT branch predictor.
package chronos_bp_pkg;
  localparam int XLEN_D    = 32;
  localparam int ENTRIES_D = 64;
  localparam int TAG_W_D   = 8;
  localparam int CTR_W_D   = 2;
  localparam int PC_STEP   = 4;
  localparam int CTR_MAX_W = 8;

  function automatic logic [CTR_MAX_W-1:0] ctr_max(input int w);
    return CTR_MAX_W'((1 << w) - 1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_weak_taken(input int w);
    return CTR_MAX_W'(1 << (w - 1));
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_weak_nt(input int w);
    return CTR_MAX_W'((1 << (w - 1)) - 1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_sat_inc(input logic [CTR_MAX_W-1:0] c, input int w);
    return (c == ctr_max(w)) ? c : c + 1'b1;
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_sat_dec(input logic [CTR_MAX_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction
endpackage

// File: rtl/branch_predictor_bht_if.sv
// Fetch-lookup and execute-update/redirect bundle between the core and the predictor.
interface bp_if #(parameter int XLEN = 32);
  logic            en;
  logic [XLEN-1:0] lkp_pc;
  logic            lkp_hit;
  logic            lkp_taken;
  logic [XLEN-1:0] lkp_next_pc;
  logic            upd_valid;
  logic            upd_is_jump;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_pred_taken;
  logic [XLEN-1:0] upd_pred_target;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output en, lkp_pc, upd_valid, upd_is_jump, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  lkp_hit, lkp_taken, lkp_next_pc, redirect_valid, redirect_pc
  );

  modport slave (
    input  en, lkp_pc, upd_valid, upd_is_jump, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output lkp_hit, lkp_taken, lkp_next_pc, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_predictor_bht_ctr.sv
// One BHT entry's saturating direction counter; load has priority over inc/dec.
module bp_sat_counter
  import chronos_bp_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_load,
  input  logic [CTR_W-1:0] i_load_val,
  output logic [CTR_W-1:0] o_ctr
);
  localparam logic [CTR_W-1:0] RST_VAL = CTR_W'(ctr_weak_nt(CTR_W));

  logic [CTR_W-1:0]     r_ctr;
  logic [CTR_MAX_W-1:0] w_cur, w_inc, w_dec;
  logic                 w_unused;

  assign w_cur    = CTR_MAX_W'(r_ctr);
  assign w_inc    = ctr_sat_inc(w_cur, CTR_W);
  assign w_dec    = ctr_sat_dec(w_cur);
  assign w_unused = ^{w_inc, w_dec};
  assign o_ctr    = r_ctr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ctr <= RST_VAL;
    else if (i_load) r_ctr <= i_load_val;
    else if (i_inc)  r_ctr <= w_inc[CTR_W-1:0];
    else if (i_dec)  r_ctr <= w_dec[CTR_W-1:0];
  end
endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped BTB + per-entry saturating-counter BHT with EX-stage redirect.
// Optional BP_PERF_CNT_EN adds lookup / mispredict performance counters.
module branch_predictor_bht
  import chronos_bp_pkg::*;
#(
  parameter int XLEN    = XLEN_D,
  parameter int ENTRIES = ENTRIES_D,
  parameter int TAG_W   = TAG_W_D,
  parameter int CTR_W   = CTR_W_D
) (
  input  logic        clk,
  input  logic        rst_n,
  bp_if.slave         bus
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0] o_perf_lookups,
  output logic [31:0] o_perf_mispredicts
`endif
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] LD_WEAK_TK = CTR_W'(ctr_weak_taken(CTR_W));
  localparam logic [CTR_W-1:0] LD_STRONG  = CTR_W'(ctr_max(CTR_W));

  logic [ENTRIES-1:0]                r_valid;
  logic [ENTRIES-1:0][TAG_W-1:0]     r_tag;
  logic [ENTRIES-1:0][XLEN-1:0]      r_target;
  logic [ENTRIES-1:0][CTR_W-1:0]     w_ctr;

  logic [IDX_W-1:0] w_lkp_idx, w_upd_idx;
  logic [TAG_W-1:0] w_lkp_tag, w_upd_tag;
  logic             w_lkp_hit, w_lkp_tk;
  logic             w_upd_hit, w_upd_tk, w_we;
  logic [CTR_W-1:0] w_ld_val;
  logic [XLEN-1:0]  w_actual_next;
  logic             w_unused;

  assign w_lkp_idx = bus.lkp_pc[IDX_W+1:2];
  assign w_lkp_tag = bus.lkp_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_upd_idx = bus.upd_pc[IDX_W+1:2];
  assign w_upd_tag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_unused  = ^{bus.lkp_pc, bus.upd_pc};

  // Lookup reads the registered tables only, so a same-cycle update is not visible.
  assign w_lkp_hit       = r_valid[w_lkp_idx] && (r_tag[w_lkp_idx] == w_lkp_tag);
  assign w_lkp_tk        = w_lkp_hit && w_ctr[w_lkp_idx][CTR_W-1];
  assign bus.lkp_hit     = w_lkp_hit;
  assign bus.lkp_taken   = w_lkp_tk;
  assign bus.lkp_next_pc = w_lkp_tk ? r_target[w_lkp_idx] : bus.lkp_pc + XLEN'(PC_STEP);

  assign w_actual_next      = bus.upd_taken ? bus.upd_target : bus.upd_pc + XLEN'(PC_STEP);
  assign bus.redirect_pc    = w_actual_next;
  assign bus.redirect_valid = bus.upd_valid &&
                              ((bus.upd_pred_taken != bus.upd_taken) ||
                               (bus.upd_taken && (bus.upd_pred_target != bus.upd_target)));

  assign w_we      = bus.en && bus.upd_valid;
  assign w_upd_tk  = bus.upd_taken || bus.upd_is_jump;
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_ld_val  = bus.upd_is_jump ? LD_STRONG : LD_WEAK_TK;

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
    logic w_sel;
    assign w_sel = w_we && (w_upd_idx == IDX_W'(e));
    bp_sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_inc      (w_sel && w_upd_hit && w_upd_tk),
      .i_dec      (w_sel && w_upd_hit && !w_upd_tk),
      .i_load     (w_sel && !w_upd_hit && w_upd_tk),
      .i_load_val (w_ld_val),
      .o_ctr      (w_ctr[e])
    );
  end

  // Any taken update (hit or allocate) writes valid/tag/target; the tag is unchanged on a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_tag    <= '0;
      r_target <= '0;
    end else if (w_we && w_upd_tk) begin
      r_valid[w_upd_idx]  <= 1'b1;
      r_tag[w_upd_idx]    <= w_upd_tag;
      r_target[w_upd_idx] <= bus.upd_target;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] r_perf_lkp, r_perf_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_lkp <= '0;
      r_perf_mis <= '0;
    end else if (bus.en) begin
      r_perf_lkp <= r_perf_lkp + 32'd1;
      if (bus.redirect_valid) r_perf_mis <= r_perf_mis + 32'd1;
    end
  end

  assign o_perf_lookups     = r_perf_lkp;
  assign o_perf_mispredicts = r_perf_mis;
`endif
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Vector-table bench for branch_predictor_bht (ENTRIES=64: idx=pc[7:2], tag=pc[15:8]).
module tb_branch_predictor_bht;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_if #(.XLEN(32)) bus ();

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_lkp, perf_mis;
  branch_predictor_bht dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                            .o_perf_lookups(perf_lkp), .o_perf_mispredicts(perf_mis));
`else
  branch_predictor_bht dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  typedef struct {
    logic        en;
    logic [31:0] lpc;
    logic        uv, uj;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        ppt;
    logic [31:0] ptgt;
    logic        hit, tk;
    logic [31:0] npc;
    logic        rv;
    logic [31:0] rpc;
  } vec_t;

  typedef struct {
    logic        hit, tk, rv;
    logic [31:0] npc, rpc;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic en, logic [31:0] lpc, logic uv, logic uj, logic [31:0] upc,
                              logic ut, logic [31:0] utgt, logic ppt, logic [31:0] ptgt,
                              logic hit, logic tk, logic [31:0] npc, logic rv, logic [31:0] rpc);
    vec_t v;
    v.en = en; v.lpc = lpc; v.uv = uv; v.uj = uj; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.ppt = ppt; v.ptgt = ptgt; v.hit = hit; v.tk = tk; v.npc = npc; v.rv = rv; v.rpc = rpc;
    return v;
  endfunction

  task automatic chk(string nm, int id, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", nm, id, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.en = v.en; bus.lkp_pc = v.lpc; bus.upd_valid = v.uv; bus.upd_is_jump = v.uj;
    bus.upd_pc = v.upc; bus.upd_taken = v.ut; bus.upd_target = v.utgt;
    bus.upd_pred_taken = v.ppt; bus.upd_pred_target = v.ptgt;
  endtask

  task automatic idle(logic [31:0] lpc);
    drive(mk(1'b1, lpc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    // en lpc uv uj upc ut utgt ppt ptgt | hit tk npc rv rpc
    tbl.push_back(mk(1, 'h100, 0, 0, 'h0,   0, 'h0,   0, 'h0,   0, 0, 'h104, 0, 'h4));
    tbl.push_back(mk(1, 'h100, 1, 0, 'h100, 1, 'h40,  0, 'h104, 0, 0, 'h104, 1, 'h40));
    tbl.push_back(mk(1, 'h100, 0, 0, 'h0,   0, 'h0,   0, 'h0,   1, 1, 'h40,  0, 'h4));
    tbl.push_back(mk(1, 'h100, 1, 0, 'h100, 0, 'h40,  1, 'h40,  1, 1, 'h40,  1, 'h104));
    tbl.push_back(mk(1, 'h100, 1, 0, 'h100, 0, 'h40,  0, 'h104, 1, 0, 'h104, 0, 'h104));
    tbl.push_back(mk(1, 'h100, 1, 0, 'h100, 0, 'h40,  0, 'h104, 1, 0, 'h104, 0, 'h104));
    tbl.push_back(mk(1, 'h100, 1, 0, 'h100, 1, 'h40,  0, 'h104, 1, 0, 'h104, 1, 'h40));
    tbl.push_back(mk(1, 'h100, 1, 0, 'h100, 1, 'h40,  0, 'h104, 1, 0, 'h104, 1, 'h40));
    tbl.push_back(mk(1, 'h100, 1, 0, 'h100, 1, 'h40,  1, 'h40,  1, 1, 'h40,  0, 'h40));
    tbl.push_back(mk(1, 'h100, 1, 0, 'h100, 1, 'h40,  1, 'h40,  1, 1, 'h40,  0, 'h40));
    tbl.push_back(mk(1, 'h100, 1, 0, 'h100, 0, 'h40,  1, 'h40,  1, 1, 'h40,  1, 'h104));
    tbl.push_back(mk(1, 'h100, 0, 0, 'h0,   0, 'h0,   0, 'h0,   1, 1, 'h40,  0, 'h4));
    tbl.push_back(mk(1, 'h100, 1, 0, 'h100, 1, 'h80,  1, 'h40,  1, 1, 'h40,  1, 'h80));
    tbl.push_back(mk(1, 'h100, 0, 0, 'h0,   0, 'h0,   0, 'h0,   1, 1, 'h80,  0, 'h4));
    tbl.push_back(mk(0, 'h100, 1, 0, 'h100, 0, 'h80,  1, 'h80,  1, 1, 'h80,  1, 'h104));
    tbl.push_back(mk(0, 'h100, 1, 0, 'h100, 0, 'h80,  1, 'h80,  1, 1, 'h80,  1, 'h104));
    tbl.push_back(mk(1, 'h100, 0, 0, 'h0,   0, 'h0,   0, 'h0,   1, 1, 'h80,  0, 'h4));
    tbl.push_back(mk(1, 'h100, 1, 0, 'h200, 1, 'h300, 0, 'h204, 1, 1, 'h80,  1, 'h300));
    tbl.push_back(mk(1, 'h100, 0, 0, 'h0,   0, 'h0,   0, 'h0,   0, 0, 'h104, 0, 'h4));
    tbl.push_back(mk(1, 'h200, 0, 0, 'h0,   0, 'h0,   0, 'h0,   1, 1, 'h300, 0, 'h4));
    tbl.push_back(mk(1, 'h180, 1, 0, 'h180, 0, 'h0,   0, 'h184, 0, 0, 'h184, 0, 'h184));
    tbl.push_back(mk(1, 'h180, 0, 0, 'h0,   0, 'h0,   0, 'h0,   0, 0, 'h184, 0, 'h4));
    tbl.push_back(mk(1, 'h180, 1, 1, 'h180, 1, 'h500, 0, 'h184, 0, 0, 'h184, 1, 'h500));
    tbl.push_back(mk(1, 'h180, 1, 0, 'h180, 0, 'h500, 1, 'h500, 1, 1, 'h500, 1, 'h184));
    tbl.push_back(mk(1, 'h180, 0, 0, 'h0,   0, 'h0,   0, 'h0,   1, 1, 'h500, 0, 'h4));
    tbl.push_back(mk(1, 'hFFFFFFFC, 1, 0, 'hFFFFFFFC, 0, 'h0, 0, 'h0, 0, 0, 'h0, 0, 'h0));
    tbl.push_back(mk(1, 'h182, 0, 0, 'h0,   0, 'h0,   0, 'h0,   1, 1, 'h500, 0, 'h4));
    tbl.push_back(mk(1, 'h100, 0, 0, 'h100, 0, 'h40,  1, 'h40,  0, 0, 'h104, 0, 'h104));

    idle('h100);
    bus.en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      exp_t e;
      @(posedge clk);
      #1;
      drive(tbl[i]);
      e.hit = tbl[i].hit; e.tk = tbl[i].tk; e.npc = tbl[i].npc;
      e.rv = tbl[i].rv; e.rpc = tbl[i].rpc;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      chk("lkp_hit",        i, 32'(bus.lkp_hit),        32'(e.hit));
      chk("lkp_taken",      i, 32'(bus.lkp_taken),      32'(e.tk));
      chk("lkp_next_pc",    i, bus.lkp_next_pc,          e.npc);
      chk("redirect_valid", i, 32'(bus.redirect_valid), 32'(e.rv));
      chk("redirect_pc",    i, bus.redirect_pc,          e.rpc);
    end

    // Async reset clears entries immediately and discards an update pending at the edge.
    @(posedge clk);
    #1;
    drive(mk(1, 'h200, 1, 0, 'h100, 1, 'h40, 0, 'h104, 0, 0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_hit", 0, 32'(bus.lkp_hit), 32'd0);
    chk("rst_async_npc", 0, bus.lkp_next_pc, 32'h204);
    @(posedge clk);
    @(negedge clk);
    idle('h100);
    bus.en = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_discard_hit", 0, 32'(bus.lkp_hit), 32'd0);
    bus.lkp_pc = 'h180;
    #1;
    chk("rst_clear_hit", 1, 32'(bus.lkp_hit), 32'd0);

`ifdef BP_PERF_CNT_EN
    chk("perf_lkp_rst", 0, perf_lkp, 32'd0);
    chk("perf_mis_rst", 0, perf_mis, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      drive(mk(1, 'h400, (i < 3), 0, 'h400, 0, 'h0, 1, 'h404, 0, 0, 0, 0, 0));
    end
    @(posedge clk);
    #1;
    idle('h100);
    bus.en = 1'b0;
    @(negedge clk);
    chk("perf_lookups",     0, perf_lkp, 32'd10);
    chk("perf_mispredicts", 0, perf_mis, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("perf_lkp_midrst", 0, perf_lkp, 32'd0);
    chk("perf_mis_midrst", 0, perf_mis, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
